uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50000000, system clock frequency.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 The block SHALL have parameters IO_MEM_MAP_BIT and UART_MEM_MAP_BIT, defaults from the shared defines, selecting the UART address decode bits.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, power of two, receive buffer entries.
REQ-005 clk  input  1  the single system clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 rx_i  input  1  asynchronous serial line, idle high.
REQ-008 mem_addr_i  input  32  CPU bus address.
REQ-009 mem_rstrb_i  input  1  CPU read strobe.
REQ-010 mem_rdata_o  output  32  read data, registered.

Function
REQ-011 rx_i SHALL pass a two-flop synchronizer, both flops resetting to 1.
REQ-012 CLKS_PER_BIT SHALL equal CLK_FREQ_HZ/BAUD_RATE (integer division); the baud counter SHALL be wide enough for CLKS_PER_BIT-1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE->START SHALL occur on the first cycle the synchronized line is 0.
REQ-015 In START, after CLKS_PER_BIT/2 cycles, the line SHALL be resampled: 0 -> DATA, 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA SHALL sample 8 bits, LSB first, one every CLKS_PER_BIT cycles, then enter STOP.
REQ-017 STOP SHALL sample once after CLKS_PER_BIT cycles: 1 -> push byte; 0 -> discard byte and set sticky frame_err; either way return to IDLE that cycle.
REQ-018 A push into a full FIFO SHALL drop the new byte and set sticky overrun; FIFO contents are unchanged.
REQ-019 UART access SHALL be mem_addr_i[IO_MEM_MAP_BIT] AND mem_addr_i[UART_MEM_MAP_BIT]; writes are ignored.
REQ-020 On a clk edge with access and mem_rstrb_i high, mem_rdata_o SHALL load {21'b0, overrun, frame_err, valid, head_byte} (bits 10,9,8,7:0); valid = FIFO non-empty; head_byte = 0 when empty.
REQ-021 That read SHALL pop the FIFO if non-empty and clear both sticky flags; a flag set in the same cycle SHALL remain set.
REQ-022 On any edge without an access read, mem_rdata_o SHALL load 0 (bus-OR friendly); read latency is exactly one cycle.
REQ-023 Simultaneous push and pop on a full FIFO SHALL succeed with no overrun; on an empty FIFO the pop is a no-op and the pushed byte is stored.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-025 Reset SHALL force FSM=IDLE, counters=0, FIFO empty, flags=0, mem_rdata_o=0, synchronizer=1.
REQ-026 Reset mid-frame SHALL abandon the frame; after release the block SHALL wait for the next falling edge and SHALL NOT push a partial byte.

Structure
REQ-027 IO_MEM_MAP_BIT, UART_MEM_MAP_BIT and status bit positions SHALL live in the shared define file.
REQ-028 The FIFO SHALL be a sub-module uart_rx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head).

Verification (CLK_FREQ_HZ=1000000, BAUD_RATE=100000, CLKS_PER_BIT=10)
REQ-029 Frame 0x55, valid stop, then read -> mem_rdata_o=0x00000155 one cycle later; next read -> 0x00000000.
REQ-030 Low pulse of 3 cycles on rx_i -> no push; read returns 0x00000000.
REQ-031 Frame 0xA3 with stop bit 0 -> read returns 0x00000200; following read returns 0x00000000.
REQ-032 Five back-to-back frames 0x01..0x05, no reads -> reads return 0x501, 0x102, 0x103, 0x104, then 0x0.
REQ-033 Assert rst low during bit 4 of a frame, release, then send 0x7E -> only 0x17E ever read.
REQ-034 FIFO full, read issued in the same cycle as stop sample of 0x99 -> no overrun; 0x99 is read last.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared address-decode and status-word definitions for uart_rx
//
// Purpose: one place for the IO / UART decode bit positions and the layout of
//          the status word returned on a CPU read.
// Contents: DEF_IO_MEM_MAP_BIT, DEF_UART_MEM_MAP_BIT  default decode bits
//           STAT_*_BIT                                status word bit positions
//           make_status()                             assembles the read word
package uart_rx_pkg;

  localparam int DEF_IO_MEM_MAP_BIT   = 22;
  localparam int DEF_UART_MEM_MAP_BIT = 1;

  localparam int STAT_OVERRUN_BIT   = 10;
  localparam int STAT_FRAME_ERR_BIT = 9;
  localparam int STAT_VALID_BIT     = 8;

  function automatic logic [31:0] make_status(input logic       overrun,
                                              input logic       frame_err,
                                              input logic       valid,
                                              input logic [7:0] data);
    logic [31:0] s;
    s                     = '0;
    s[STAT_OVERRUN_BIT]   = overrun;
    s[STAT_FRAME_ERR_BIT] = frame_err;
    s[STAT_VALID_BIT]     = valid;
    s[7:0]                = data;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO for uart_rx
//
// Purpose: small synchronous FIFO with first-word-fall-through head output.
// Ports:   clk, rst (async, active-low)
//          push_i/data_i  write request; dropped when full unless popping too
//          pop_i          read request; ignored when empty
//          head_o         oldest entry (undefined content when empty)
//          full_o/empty_o occupancy status
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a write when it is being read.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - memory-mapped 8N1 UART receiver with receive FIFO
//
// Purpose: samples an asynchronous serial line, assembles 8N1 frames and
//          queues bytes for the CPU, reporting framing and overrun errors.
// Ports:   clk           system clock, rising edge
//          rst           asynchronous active-low reset
//          rx_i          serial input, idle high
//          mem_addr_i    CPU address, decoded on two single bits
//          mem_rstrb_i   CPU read strobe
//          mem_rdata_o   registered read data, zero when not selected
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 50000000,
  parameter int BAUD_RATE        = 115200,
  parameter int IO_MEM_MAP_BIT   = DEF_IO_MEM_MAP_BIT,
  parameter int UART_MEM_MAP_BIT = DEF_UART_MEM_MAP_BIT,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_rstrb_i,
  output logic [31:0] mem_rdata_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic             rx_meta_q, rx_sync_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             push;
  logic             frame_bad;
  logic             rd_hit;
  logic             pop;
  logic             overrun_set;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  // Only the two decode bits of the address matter.
  logic             unused_addr;
  assign unused_addr = ^mem_addr_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // Recheck mid start bit; a line back high was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          push      = rx_sync_q;
          frame_bad = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_hit      = mem_rstrb_i && mem_addr_i[IO_MEM_MAP_BIT] && mem_addr_i[UART_MEM_MAP_BIT];
  assign pop         = rd_hit && !fifo_empty;
  assign overrun_set = push && fifo_full && !pop;

  // A read clears the sticky flags, but an event in the same cycle wins.
  always_comb begin
    overrun_d   = (overrun_q && !rd_hit) || overrun_set;
    frame_err_d = (frame_err_q && !rd_hit) || frame_bad;
    rdata_d     = '0;
    if (rd_hit) begin
      rdata_d = make_status(overrun_q, frame_err_q, !fifo_empty,
                            fifo_empty ? 8'h00 : fifo_head);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_rdata_o = rdata_q;

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking testbench for uart_rx
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  localparam logic [31:0] UART_ADDR = (32'h1 << DEF_IO_MEM_MAP_BIT) | (32'h1 << DEF_UART_MEM_MAP_BIT);
  localparam logic [31:0] IO_ONLY   = (32'h1 << DEF_IO_MEM_MAP_BIT);

  localparam int K_FRAME = 0;
  localparam int K_READ  = 1;
  localparam int K_GLTCH = 2;
  localparam int K_IDLE  = 3;
  localparam int K_NOACC = 4;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    bit          stop_ok;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_i = 1'b1;
  logic [31:0] mem_addr_i = '0;
  logic        mem_rstrb_i = 1'b0;
  logic [31:0] mem_rdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t        vecs[$];
  logic [7:0]  model_q[$];
  bit          m_ovr;
  bit          m_ferr;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ_HZ (1000000),
    .BAUD_RATE   (100000),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .mem_addr_i  (mem_addr_i),
    .mem_rstrb_i (mem_rstrb_i),
    .mem_rdata_o (mem_rdata_o)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
    rx_i = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One read cycle; also confirms the bus drops back to zero afterwards.
  task automatic read_check(input string name, input int idx, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr_i  = addr;
    mem_rstrb_i = 1'b1;
    @(negedge clk);
    mem_rstrb_i = 1'b0;
    mem_addr_i  = '0;
    check(name, idx, mem_rdata_o, exp);
    @(negedge clk);
    check({name, "_clear"}, idx, mem_rdata_o, 32'h0);
  endtask

  function automatic void add(input int kind, input logic [7:0] d, input bit ok, input logic [31:0] exp);
    vec_t v;
    v.kind = kind; v.data = d; v.stop_ok = ok; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Reference: status word from the queue contents and sticky flags.
  function automatic logic [31:0] model_read();
    logic [31:0] w;
    logic [7:0]  h;
    h = (model_q.size() != 0) ? model_q[0] : 8'h00;
    w = {21'b0, m_ovr, m_ferr, (model_q.size() != 0), h};
    if (model_q.size() != 0) void'(model_q.pop_front());
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    return w;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input bit ok);
    if (!ok)                          m_ferr = 1'b1;
    else if (model_q.size() >= DEPTH) m_ovr  = 1'b1;
    else                              model_q.push_back(d);
  endfunction

  initial begin
    logic [31:0] exp;
    logic [7:0]  d;
    bit          ok;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdata", 0, mem_rdata_o, 32'h0);
    rst = 1'b1;
    idle(5);
    read_check("reset_empty_read", 0, UART_ADDR, 32'h0);

    // Directed table
    add(K_FRAME, 8'h55, 1, 0); add(K_IDLE, 0, 0, 0);
    add(K_READ, 0, 0, 32'h155); add(K_READ, 0, 0, 32'h0);
    add(K_GLTCH, 0, 0, 0); add(K_IDLE, 0, 0, 0); add(K_READ, 0, 0, 32'h0);
    add(K_FRAME, 8'hA3, 0, 0); add(K_IDLE, 0, 0, 0);
    add(K_READ, 0, 0, 32'h200); add(K_READ, 0, 0, 32'h0);
    for (int i = 1; i <= 5; i++) add(K_FRAME, 8'(i), 1, 0);
    add(K_IDLE, 0, 0, 0);
    add(K_READ, 0, 0, 32'h501); add(K_READ, 0, 0, 32'h102);
    add(K_READ, 0, 0, 32'h103); add(K_READ, 0, 0, 32'h104); add(K_READ, 0, 0, 32'h0);
    add(K_FRAME, 8'h3C, 1, 0); add(K_IDLE, 0, 0, 0);
    add(K_NOACC, 0, 0, 32'h0); add(K_READ, 0, 0, 32'h13C); add(K_READ, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_FRAME: send_frame(vecs[i].data, vecs[i].stop_ok);
        K_READ:  read_check("vec_read", i, UART_ADDR, vecs[i].exp);
        K_NOACC: read_check("vec_noaccess", i, IO_ONLY, vecs[i].exp);
        K_GLTCH: begin rx_i = 1'b0; repeat (3) @(negedge clk); rx_i = 1'b1; end
        default: idle(20);
      endcase
    end

    // Reset during bit 4 abandons the frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_rdata", 0, mem_rdata_o, 32'h0);
    repeat (2) @(negedge clk);
    rx_i = 1'b1;
    rst  = 1'b1;
    idle(30);
    send_frame(8'h7E, 1);
    idle(5);
    read_check("after_reset", 0, UART_ADDR, 32'h17E);
    read_check("after_reset", 1, UART_ADDR, 32'h0);

    // Full FIFO, read lands on the stop-sample edge of the fifth frame.
    // Start bit seen by rx_i before edge P0 is sampled for stop at edge P97.
    send_frame(8'h11, 1); send_frame(8'h22, 1);
    send_frame(8'h33, 1); send_frame(8'h44, 1);
    idle(5);
    fork
      send_frame(8'h99, 1);
      begin
        repeat (97) @(negedge clk);
        mem_addr_i  = UART_ADDR;
        mem_rstrb_i = 1'b1;
        @(negedge clk);
        mem_rstrb_i = 1'b0;
        mem_addr_i  = '0;
        check("full_pop_push", 0, mem_rdata_o, 32'h111);
      end
    join
    idle(5);
    read_check("full_pop_push", 1, UART_ADDR, 32'h122);
    read_check("full_pop_push", 2, UART_ADDR, 32'h133);
    read_check("full_pop_push", 3, UART_ADDR, 32'h144);
    read_check("full_pop_push", 4, UART_ADDR, 32'h199);
    read_check("full_pop_push", 5, UART_ADDR, 32'h0);

    // Randomized frames and reads against the queue model
    model_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 7) begin
        d  = 8'($urandom);
        ok = ($urandom_range(0, 4) != 0);
        send_frame(d, ok);
        model_frame(d, ok);
        idle($urandom_range(12, 40));
      end else begin
        exp = model_read();
        read_check("rand_read", it, UART_ADDR, exp);
      end
    end
    for (int i = 0; i <= DEPTH; i++) begin
      exp = model_read();
      read_check("rand_drain", i, UART_ADDR, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
